// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   - Default frame geometry (data bits, prescale input width)
//   - 3-bit state encoding shared by the TX framer and the RX block
//   - Parity type encoding used on PAR_TYP
// No ports; imported with "import uart_pkg::*;".
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_PRESCALE_WIDTH = 6;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Enum values are tied to the shared encoding so RX and TX agree on it.
    typedef enum logic [2:0] {
        TX_IDLE   = IDLE,
        TX_START  = START,
        TX_DATA   = DATA,
        TX_PARITY = PARITY,
        TX_STOP   = STOP
    } txState_e;

endpackage

// File: rtl/uart_tx_frame_gen_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_gen_if
// Byte-source / serial-pin bundle of the UART transmit framer.
//   P_DATA     byte to send, sampled on accept
//   Data_Valid request strobe, honoured only while Busy=0
//   PAR_EN     parity bit enable, sampled on accept
//   PAR_TYP    0 = even, 1 = odd, sampled on accept
//   Prescale   CLK cycles per bit, 0 treated as 1, sampled on accept
//   TX_OUT     serial line, idle high
//   Busy       frame in progress
// Modports: master = byte source side, slave = framer side.
// ---------------------------------------------------------------------------
interface uart_tx_frame_gen_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
);

    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_tx_bit_timer
// Per-bit cycle counter (0..P-1) and data bit index (0..DATA_WIDTH-1) for the
// transmit framer; the transmit mirror of the RX edge/bit counter.
//   CLK, RST        clock, asynchronous active-low reset
//   clear_i         restart both counters (frame accept)
//   enable_i        count cycles (frame in progress)
//   dataPhase_i     advance the bit index on each bit end
//   prescaleMax_i   P-1, the last cycle of a bit
//   bitDone_o       current cycle is the last cycle of the current bit
//   lastBit_o       bit index is at DATA_WIDTH-1
//   bitIdx_o        current data bit index
// ---------------------------------------------------------------------------
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH,
    localparam int IDX_W         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  logic                      dataPhase_i,
    input  logic [PRESCALE_WIDTH-1:0] prescaleMax_i,
    output logic                      bitDone_o,
    output logic                      lastBit_o,
    output logic [IDX_W-1:0]          bitIdx_o
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [IDX_W-1:0]          idx_q;

    assign bitDone_o = enable_i && (cnt_q == prescaleMax_i);
    assign lastBit_o = (idx_q == IDX_W'(DATA_WIDTH - 1));
    assign bitIdx_o  = idx_q;

    // Cycle counter wraps at P-1; the bit index only moves on that wrap and
    // only while data bits are being shifted, so neither can overrun.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            if (enable_i) begin
                cnt_q <= bitDone_o ? '0 : cnt_q + PRESCALE_WIDTH'(1);
            end
            if (bitDone_o && dataPhase_i) begin
                idx_q <= lastBit_o ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_gen
// Transmit-side UART framer: start bit, DATA_WIDTH data bits LSB first,
// optional even/odd parity bit, stop bit; each bit held Prescale CLK cycles.
//   CLK   clock
//   RST   asynchronous active-low reset
//   bus   uart_tx_frame_gen_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP,
//         Prescale in; TX_OUT, Busy out, both registered)
// ---------------------------------------------------------------------------
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    uart_tx_frame_gen_if.slave  bus
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    txState_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]     shadow_q;
    logic                      parEn_q;
    logic                      parTyp_q;
    logic [PRESCALE_WIDTH-1:0] pMax_q;
    logic                      txOut_q, txOut_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic                      bitDone;
    logic                      lastBit;
    logic                      parityBit;
    logic [IDX_W-1:0]          bitIdx;
    logic [IDX_W-1:0]          nextIdx;

    assign accept    = (state_q == TX_IDLE) && bus.Data_Valid;
    assign parityBit = (^shadow_q) ^ (parTyp_q == PAR_ODD);

    assign bus.TX_OUT = txOut_q;
    assign bus.Busy   = busy_q;

    uart_tx_bit_timer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_timer (
        .CLK           (CLK),
        .RST           (RST),
        .clear_i       (accept),
        .enable_i      (state_q != TX_IDLE),
        .dataPhase_i   (state_q == TX_DATA),
        .prescaleMax_i (pMax_q),
        .bitDone_o     (bitDone),
        .lastBit_o     (lastBit),
        .bitIdx_o      (bitIdx)
    );

    // Frame settings are captured once on accept so that later input changes
    // cannot disturb the frame in flight; Prescale 0 behaves like 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow_q <= '0;
            parEn_q  <= 1'b0;
            parTyp_q <= 1'b0;
            pMax_q   <= '0;
        end else if (accept) begin
            shadow_q <= bus.P_DATA;
            parEn_q  <= bus.PAR_EN;
            parTyp_q <= bus.PAR_TYP;
            pMax_q   <= (bus.Prescale == '0) ? '0 : bus.Prescale - PRESCALE_WIDTH'(1);
        end
    end

    // State and the registered line/busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= TX_IDLE;
            txOut_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            txOut_q <= txOut_d;
            busy_q  <= busy_d;
        end
    end

    // Next state, plus the line value for the next cycle. The output mux looks
    // at the next state and next bit index so TX_OUT can be a plain register
    // that changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        nextIdx = '0;
        txOut_d = 1'b1;

        case (state_q)
            TX_IDLE:   if (bus.Data_Valid) state_d = TX_START;
            TX_START:  if (bitDone)        state_d = TX_DATA;
            TX_DATA:   if (bitDone && lastBit) state_d = parEn_q ? TX_PARITY : TX_STOP;
            TX_PARITY: if (bitDone)        state_d = TX_STOP;
            TX_STOP:   if (bitDone)        state_d = TX_IDLE;
            default:                       state_d = TX_IDLE;
        endcase

        if (state_q == TX_DATA) begin
            nextIdx = (bitDone && !lastBit) ? bitIdx + IDX_W'(1) : bitIdx;
        end

        case (state_d)
            TX_START:  txOut_d = 1'b0;
            TX_DATA:   txOut_d = shadow_q[nextIdx];
            TX_PARITY: txOut_d = parityBit;
            default:   txOut_d = 1'b1;
        endcase

        busy_d = (state_d != TX_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_gen
// Directed bench for uart_tx_frame_gen: hand-written expected line sequences
// checked every cycle, plus reset, busy protection and back-to-back cases.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_gen;
    import uart_pkg::*;

    logic CLK;
    logic RST;
    int   checkCount;
    int   failCount;

    uart_tx_frame_gen_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) txBus();

    uart_tx_frame_gen #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (txBus)
    );

    // 10 time-unit clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts, and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a request at the falling edge so the next rising edge accepts it.
    task automatic applyStimulus(input logic [7:0] data, input logic parEn,
                                 input logic parTyp, input logic [5:0] presc);
        @(negedge CLK);
        txBus.P_DATA     = data;
        txBus.PAR_EN     = parEn;
        txBus.PAR_TYP    = parTyp;
        txBus.Prescale   = presc;
        txBus.Data_Valid = 1'b1;
    endtask

    // Walks the frame cycle by cycle from the accept edge. frame[i] is the
    // i-th bit on the line in time order. injectAt: cycle at which a new
    // request with different settings is pulsed while busy (-1 = none).
    // swapAt: cycle at which P_DATA is replaced by swapData (-1 = none).
    task automatic checkFrame(input string name, input logic [11:0] frame, input int nBits,
                              input int p, input logic [7:0] expByte, input bit holdValid,
                              input int injectAt, input int swapAt, input logic [7:0] swapData,
                              input int idleN);
        logic [7:0] rxByte;
        rxByte = '0;
        for (int c = 0; c < nBits * p; c++) begin
            @(posedge CLK);
            #1;
            checkOutput($sformatf("%s tx c%0d", name, c), {31'd0, txBus.TX_OUT}, {31'd0, frame[c / p]});
            checkOutput($sformatf("%s busy c%0d", name, c), {31'd0, txBus.Busy}, 32'd1);
            if (c >= p && c < 9 * p && (c % p) == p / 2) rxByte[c / p - 1] = txBus.TX_OUT;
            if (c == 0 && !holdValid) txBus.Data_Valid = 1'b0;
            if (c == injectAt) begin
                txBus.P_DATA     = 8'h3C;
                txBus.Prescale   = 6'd2;
                txBus.PAR_EN     = 1'b0;
                txBus.PAR_TYP    = PAR_ODD;
                txBus.Data_Valid = 1'b1;
            end
            if (injectAt >= 0 && c == injectAt + 1) txBus.Data_Valid = 1'b0;
            if (c == swapAt) txBus.P_DATA = swapData;
        end
        checkOutput($sformatf("%s rxByte", name), {24'd0, rxByte}, {24'd0, expByte});
        for (int i = 0; i < idleN; i++) begin
            @(posedge CLK);
            #1;
            checkOutput($sformatf("%s idle tx %0d", name, i), {31'd0, txBus.TX_OUT}, 32'd1);
            checkOutput($sformatf("%s idle busy %0d", name, i), {31'd0, txBus.Busy}, 32'd0);
        end
    endtask

    initial begin
        checkCount       = 0;
        failCount        = 0;
        RST              = 1'b0;
        txBus.P_DATA     = '0;
        txBus.Data_Valid = 1'b0;
        txBus.PAR_EN     = 1'b0;
        txBus.PAR_TYP    = PAR_EVEN;
        txBus.Prescale   = '0;

        // Reset values.
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset tx", {31'd0, txBus.TX_OUT}, 32'd1);
        checkOutput("reset busy", {31'd0, txBus.Busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Reset mid-frame: 0xA5 at P=8, reset lands in the data phase.
        applyStimulus(8'hA5, 1'b1, PAR_EVEN, 6'd8);
        @(posedge CLK);
        #1;
        txBus.Data_Valid = 1'b0;
        repeat (29) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        checkOutput("midreset tx", {31'd0, txBus.TX_OUT}, 32'd1);
        checkOutput("midreset busy", {31'd0, txBus.Busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            checkOutput($sformatf("postreset tx %0d", i), {31'd0, txBus.TX_OUT}, 32'd1);
            checkOutput($sformatf("postreset busy %0d", i), {31'd0, txBus.Busy}, 32'd0);
        end

        // Even parity 0xA5, P=8: 0,1,0,1,0,0,1,0,1,0,1; a 0x3C request with
        // different settings is pulsed at cycle 20 and must leave no trace.
        applyStimulus(8'hA5, 1'b1, PAR_EVEN, 6'd8);
        checkFrame("evenA5", 12'h54A, 11, 8, 8'hA5, 1'b0, 20, -1, 8'h00, 6);

        // Odd parity 0x00, P=4: eight zero data bits, parity 1, stop 1.
        applyStimulus(8'h00, 1'b1, PAR_ODD, 6'd4);
        checkFrame("odd00", 12'h600, 11, 4, 8'h00, 1'b0, -1, -1, 8'h00, 2);

        // No parity 0xFF, P=1: 0 then nine 1s.
        applyStimulus(8'hFF, 1'b0, PAR_EVEN, 6'd1);
        checkFrame("noparFF", 12'h3FE, 10, 1, 8'hFF, 1'b0, -1, -1, 8'h00, 2);

        // Prescale 0 behaves as 1.
        applyStimulus(8'hFF, 1'b0, PAR_EVEN, 6'd0);
        checkFrame("presc0", 12'h3FE, 10, 1, 8'hFF, 1'b0, -1, -1, 8'h00, 2);

        // Back-to-back with Data_Valid held: 0x55 then 0xAA, P=2, one idle
        // cycle between the first stop bit and the second start bit.
        applyStimulus(8'h55, 1'b0, PAR_EVEN, 6'd2);
        checkFrame("b2b55", 12'h2AA, 10, 2, 8'h55, 1'b1, -1, 5, 8'hAA, 1);
        checkFrame("b2bAA", 12'h354, 10, 2, 8'hAA, 1'b0, -1, -1, 8'h00, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_gen.md
# uart_tx_frame_gen

Transmit-side UART framer: accepts a parallel byte with a one-cycle valid strobe and shifts out a complete asynchronous frame on TX_OUT, LSB first. The frame is start bit, DATA_WIDTH data bits, optional even/odd parity, and stop bit. Each bit is held for Prescale CLK cycles, using the same prescale convention as the receive path's edge/bit counting, so TX and RX share a clock and Prescale setting. It sits between the system-side byte source and the serial pin.

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_WIDTH, 6, width of Prescale input
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-low
- P_DATA  input  DATA_WIDTH  byte to send; sampled only on accept
- Data_Valid  input  1  request strobe; honoured only when Busy=0
- PAR_EN  input  1  1 = parity bit inserted; sampled on accept
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept
- Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; sampled on accept; 0 treated as 1
- TX_OUT  output  1  serial line, idle high
- Busy  output  1  frame in progress

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0.
- Accept: when Data_Valid=1 in IDLE, register P_DATA, PAR_EN, PAR_TYP and Prescale (0→1), then move to START.
  - Later input changes never affect the frame in flight.
- START: TX_OUT=0 for P cycles, then DATA.
- DATA: TX_OUT = shadow[bit_idx] for P cycles per bit, bit_idx 0..DATA_WIDTH-1.
  - After the last bit: go to PARITY if PAR_EN, else STOP.
- PARITY: TX_OUT = ^shadow XOR PAR_TYP for P cycles, then STOP.
- STOP: TX_OUT=1 for P cycles, then IDLE.
- Parity is computed from the latched data, not from live P_DATA.
- All state/bit transitions fire when the cycle counter reaches P-1.
  - Counter then wraps to 0.
  - Bit index increments only on that wrap.
  - No counter ever exceeds P-1 or DATA_WIDTH-1.
- Data_Valid while Busy=1 is ignored: not queued, not latched.
- TX_OUT and Busy are registered outputs, with no combinational path from inputs.

## Timing
- Reset (async assert, any state): TX_OUT=1, Busy=0, state IDLE, counters and shadow registers 0.
  - A frame in progress is abandoned immediately and the line returns high.
- Accept at edge k: TX_OUT=0 and Busy=1 from cycle k+1.
- Frame length F = (DATA_WIDTH + 2 + PAR_EN) × P cycles.
  - Busy is high for exactly F cycles.
  - TX_OUT returns to IDLE behaviour in cycle k+1+F.
- Back-to-back: the earliest next accept is in cycle k+1+F, the first IDLE cycle.
  - This guarantees at least P+1 high cycles (stop bit plus one idle cycle) between frames.
- P=1: one bit per cycle, with the same state sequence and no skipped bits.

## Structure
- Shared package uart_pkg holds:
  - state encoding localparams IDLE/START/DATA/PARITY/STOP (3 bits)
  - PAR_EVEN=0 and PAR_ODD=1
  - default DATA_WIDTH and PRESCALE_WIDTH
- RX uses the same package.
- Sub-module uart_tx_bit_timer counts per-bit cycles (0..P-1) and the bit index, and emits bit_done.
  - It is the transmit mirror of the RX edge/bit counter.
  - The top level holds the FSM, shadow registers, parity and the output mux.

## Test plan
- Reset values: assert RST mid-frame (Prescale=8, 0xA5, DATA state) → TX_OUT=1 and Busy=0 immediately; after release, IDLE and no residual bits.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 → line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; Busy high 88 cycles.
- Odd parity: P_DATA=0x00, PAR_EN=1, PAR_TYP=1, Prescale=4 → parity bit 1; frame 44 cycles.
- No parity, minimal prescale: P_DATA=0xFF, PAR_EN=0, Prescale=1 → 0 then eight 1s then stop 1; Busy 10 cycles.
- Prescale=0 → timing identical to Prescale=1.
- Busy protection: pulse Data_Valid with 0x3C at cycle 20 of an 0xA5 frame → 0xA5 frame unchanged; 0x3C never sent. Change P_DATA/Prescale mid-frame → no effect.
- Back-to-back: hold Data_Valid=1 with 0x55 then 0xAA → second start bit begins exactly one idle-high cycle after the first stop bit ends.
- Loopback: TX_OUT to the RX block with shared Prescale=8 → RX recovers 0xA5 with no parity error.
